// File: rtl/renkon_layer_seq.sv
// -----------------------------------------------------------------------------
// renkon_layer_seq
//
// Upstream layer sequencer for the renkon convolution engine. A host-written
// descriptor table (one entry per layer) is walked in order. For each layer
// the descriptor is registered onto the parameter outputs, a one-cycle `req`
// is issued to the renkon controller, and the sequencer waits for `ack`
// before moving on. The host sees one start/done handshake per network pass.
//
// Optional feature (compile-time macro RENKON_SEQ_TIMEOUT_EN):
//   A WAIT-state watchdog. If `ack` does not arrive within TIMEOUT wait
//   cycles the run is aborted through DONE with the sticky `err` flag set.
//   Without the macro `err` is tied to 0 and WAIT lasts indefinitely.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   cfg_we/layer/field/  descriptor field write (honoured only in IDLE)
//   cfg_wdata
//   start, num_layers    run request; layer count sampled with start
//   busy, done, err      run status (done is a one-cycle pulse)
//   layer_idx, req, ack  per-layer handshake with the controller
//   in_offset..pool_en   registered parameters of the issued layer
// -----------------------------------------------------------------------------
module renkon_layer_seq #(
  parameter int LAYERS  = 16,
  parameter int LWIDTH  = 10,
  parameter int IMGSIZE = 12,
  parameter int NETSIZE = 11,
  parameter int TIMEOUT = 1048575
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic [$clog2(LAYERS)-1:0]    cfg_layer,
  input  logic [3:0]                   cfg_field,
  input  logic [15:0]                  cfg_wdata,
  input  logic                         start,
  input  logic [$clog2(LAYERS+1)-1:0]  num_layers,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [$clog2(LAYERS)-1:0]    layer_idx,
  output logic                         req,
  input  logic                         ack,
  output logic [IMGSIZE-1:0]           in_offset,
  output logic [IMGSIZE-1:0]           out_offset,
  output logic [NETSIZE-1:0]           net_offset,
  output logic [LWIDTH-1:0]            total_in,
  output logic [LWIDTH-1:0]            total_out,
  output logic [LWIDTH-1:0]            img_size,
  output logic [LWIDTH-1:0]            conv_size,
  output logic [LWIDTH-1:0]            conv_pad,
  output logic [LWIDTH-1:0]            pool_size,
  output logic                         bias_en,
  output logic                         relu_en,
  output logic                         pool_en
);

  localparam int IDX_W = $clog2(LAYERS);
  localparam int NL_W  = $clog2(LAYERS+1);

  // The watchdog counter is 20 bits wide, so the limit must fit in it.
  if (TIMEOUT < 1 || TIMEOUT > 1048575) begin : g_bad_timeout
    $error("renkon_layer_seq: TIMEOUT must be in 1..1048575");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [IMGSIZE-1:0] in_offset;
    logic [IMGSIZE-1:0] out_offset;
    logic [NETSIZE-1:0] net_offset;
    logic [LWIDTH-1:0]  total_in;
    logic [LWIDTH-1:0]  total_out;
    logic [LWIDTH-1:0]  img_size;
    logic [LWIDTH-1:0]  conv_size;
    logic [LWIDTH-1:0]  conv_pad;
    logic [LWIDTH-1:0]  pool_size;
    logic               bias_en;
    logic               relu_en;
    logic               pool_en;
  } desc_t;

  state_t           r_state;
  desc_t            r_table [LAYERS];
  desc_t            r_out;
  logic             r_busy;
  logic             r_done;
  logic             r_req;
  logic [IDX_W-1:0] r_layer_idx;
  logic [IDX_W-1:0] r_last;       // index of the final layer of this run

  logic [NL_W-1:0]  w_nl_m1;
  logic [IDX_W-1:0] w_last;
  logic             w_unused;

  // Last layer index = min(num_layers, LAYERS) - 1. Only meaningful when
  // num_layers is non-zero; the zero case bypasses the walk entirely.
  assign w_nl_m1 = num_layers - NL_W'(1);
  assign w_last  = (num_layers >= NL_W'(LAYERS)) ? IDX_W'(LAYERS-1)
                                                 : w_nl_m1[IDX_W-1:0];

  // Data bits above the widest field are don't-care.
  assign w_unused = ^cfg_wdata;

  // ---------------------------------------------------------------------------
  // Descriptor table. Writes are accepted only while idle so that a running
  // pass always sees a stable table.
  // NOTE: the table is plain storage with no reset branch; clearing a memory
  // on reset would prevent RAM inference and costs a clear sequence nobody
  // needs, since the host always writes descriptors before a run.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (cfg_we && r_state == S_IDLE) begin
      case (cfg_field)
        4'd0: r_table[cfg_layer].in_offset  <= cfg_wdata[IMGSIZE-1:0];
        4'd1: r_table[cfg_layer].out_offset <= cfg_wdata[IMGSIZE-1:0];
        4'd2: r_table[cfg_layer].net_offset <= cfg_wdata[NETSIZE-1:0];
        4'd3: r_table[cfg_layer].total_in   <= cfg_wdata[LWIDTH-1:0];
        4'd4: r_table[cfg_layer].total_out  <= cfg_wdata[LWIDTH-1:0];
        4'd5: r_table[cfg_layer].img_size   <= cfg_wdata[LWIDTH-1:0];
        4'd6: r_table[cfg_layer].conv_size  <= cfg_wdata[LWIDTH-1:0];
        4'd7: r_table[cfg_layer].conv_pad   <= cfg_wdata[LWIDTH-1:0];
        4'd8: r_table[cfg_layer].pool_size  <= cfg_wdata[LWIDTH-1:0];
        4'd9: begin
          r_table[cfg_layer].bias_en <= cfg_wdata[0];
          r_table[cfg_layer].relu_en <= cfg_wdata[1];
          r_table[cfg_layer].pool_en <= cfg_wdata[2];
        end
        default: ;  // fields 10-15 are reserved
      endcase
    end
  end

`ifdef RENKON_SEQ_TIMEOUT_EN
  localparam logic [19:0] TO_LAST = 20'(TIMEOUT - 1);
  logic [19:0] r_wait_cnt;
  logic        r_err;
`endif

  // ---------------------------------------------------------------------------
  // Sequencer FSM. Every output is registered: each branch sets the outputs
  // for the state it is entering, so they line up with the state cycle.
  // NOTE: all state here uses non-blocking assignments so every branch reads
  // the pre-edge values; blocking assignments would make results depend on
  // statement order and mismatch between simulation and synthesis.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_req       <= 1'b0;
      r_layer_idx <= '0;
      r_last      <= '0;
      r_out       <= '0;
`ifdef RENKON_SEQ_TIMEOUT_EN
      r_wait_cnt  <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_req  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_layer_idx <= '0;
            r_last      <= w_last;
            r_busy      <= 1'b1;
`ifdef RENKON_SEQ_TIMEOUT_EN
            r_err       <= 1'b0;
`endif
            if (num_layers == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          r_out   <= r_table[r_layer_idx];
          r_req   <= 1'b1;
          r_state <= S_REQ;
        end

        // ack arriving together with req is deliberately not looked at.
        S_REQ: begin
          r_state <= S_WAIT;
`ifdef RENKON_SEQ_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
        end

        S_WAIT: begin
          if (ack) begin
            if (r_layer_idx == r_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_layer_idx <= r_layer_idx + IDX_W'(1);
              r_state     <= S_LOAD;
            end
          end
`ifdef RENKON_SEQ_TIMEOUT_EN
          // The limit is reached on the TIMEOUT-th wait cycle without ack;
          // an ack on that very cycle takes the branch above instead.
          else if (r_wait_cnt == TO_LAST) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 20'd1;
          end
`endif
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign req        = r_req;
  assign layer_idx  = r_layer_idx;
`ifdef RENKON_SEQ_TIMEOUT_EN
  assign err        = r_err;
`else
  assign err        = 1'b0;
`endif

  assign in_offset  = r_out.in_offset;
  assign out_offset = r_out.out_offset;
  assign net_offset = r_out.net_offset;
  assign total_in   = r_out.total_in;
  assign total_out  = r_out.total_out;
  assign img_size   = r_out.img_size;
  assign conv_size  = r_out.conv_size;
  assign conv_pad   = r_out.conv_pad;
  assign pool_size  = r_out.pool_size;
  assign bias_en    = r_out.bias_en;
  assign relu_en    = r_out.relu_en;
  assign pool_en    = r_out.pool_en;

endmodule

// File: tb/tb_renkon_layer_seq.sv
// -----------------------------------------------------------------------------
// tb_renkon_layer_seq
//
// Scoreboard bench for renkon_layer_seq. The stimulus side keeps a model of
// the descriptor table (raw 16-bit writes, fields >= 10 discarded) and, for
// every run it launches, pushes the expected sequence of layer requests and
// the final done onto a queue. An independent monitor pops and compares on
// every req/done the design presents. With RENKON_SEQ_TIMEOUT_EN the DUT is
// built with TIMEOUT=8 and the watchdog cases are exercised as well.
// -----------------------------------------------------------------------------
module tb_renkon_layer_seq;

  localparam int LAYERS = 16;
  localparam int IDX_W  = 4;
  localparam int NL_W   = 5;
`ifdef RENKON_SEQ_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1048575;
`endif

  logic             clk;
  logic             rst;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_layer;
  logic [3:0]       cfg_field;
  logic [15:0]      cfg_wdata;
  logic             start;
  logic [NL_W-1:0]  num_layers;
  logic             busy, done, err, req, ack;
  logic [IDX_W-1:0] layer_idx;
  logic [11:0]      in_offset, out_offset;
  logic [10:0]      net_offset;
  logic [9:0]       total_in, total_out, img_size, conv_size, conv_pad, pool_size;
  logic             bias_en, relu_en, pool_en;

  renkon_layer_seq #(
    .LAYERS (LAYERS),
    .LWIDTH (10),
    .IMGSIZE(12),
    .NETSIZE(11),
    .TIMEOUT(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_layer (cfg_layer),
    .cfg_field (cfg_field),
    .cfg_wdata (cfg_wdata),
    .start     (start),
    .num_layers(num_layers),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .layer_idx (layer_idx),
    .req       (req),
    .ack       (ack),
    .in_offset (in_offset),
    .out_offset(out_offset),
    .net_offset(net_offset),
    .total_in  (total_in),
    .total_out (total_out),
    .img_size  (img_size),
    .conv_size (conv_size),
    .conv_pad  (conv_pad),
    .pool_size (pool_size),
    .bias_en   (bias_en),
    .relu_en   (relu_en),
    .pool_en   (pool_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- scoreboard
  typedef struct {
    bit           is_done;
    int           idx;
    logic [127:0] desc;
    bit           err;
  } exp_t;

  exp_t        exp_q [$];
  logic [15:0] mdl [LAYERS][10];
  int          n_checks = 0;
  int          n_bad    = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
    n_checks++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Expected parameter word for a layer, taken from the raw model writes and
  // cut to each field's width.
  function automatic logic [127:0] exp_desc(input int l);
    logic [97:0] v;
    v = {mdl[l][0][11:0], mdl[l][1][11:0], mdl[l][2][10:0],
         mdl[l][3][9:0], mdl[l][4][9:0], mdl[l][5][9:0],
         mdl[l][6][9:0], mdl[l][7][9:0], mdl[l][8][9:0],
         mdl[l][9][0], mdl[l][9][1], mdl[l][9][2]};
    return 128'(v);
  endfunction

  function automatic logic [127:0] act_desc();
    return 128'({in_offset, out_offset, net_offset, total_in, total_out, img_size,
                 conv_size, conv_pad, pool_size, bias_en, relu_en, pool_en});
  endfunction

  function automatic logic [127:0] all_outs();
    return {busy, done, err, layer_idx, req, act_desc()} ;
  endfunction

  task automatic push_exp(input bit is_done, input int idx, input logic [127:0] desc, input bit e);
    exp_t x;
    x.is_done = is_done;
    x.idx     = idx;
    x.desc    = desc;
    x.err     = e;
    exp_q.push_back(x);
  endtask

  // ------------------------------------------------------------------- monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (req === 1'b1) begin
        if (exp_q.size() == 0) check("unexpected_req", req, 0);
        else begin
          e = exp_q.pop_front();
          check("req_is_layer", e.is_done, 0);
          check("req_layer_idx", layer_idx, e.idx);
          check("req_params", act_desc(), e.desc);
        end
      end
      if (done === 1'b1) begin
        if (exp_q.size() == 0) check("unexpected_done", done, 0);
        else begin
          e = exp_q.pop_front();
          check("done_is_end", e.is_done, 1);
          check("done_err", err, e.err);
        end
      end
    end
  end

  // Hard time limit so the bench always ends.
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit expired");
  end

  // ---------------------------------------------------------------- stimulus
  task automatic wr(input int l, input int f, input logic [15:0] d);
    cfg_we    = 1'b1;
    cfg_layer = IDX_W'(l);
    cfg_field = 4'(f);
    cfg_wdata = d;
    tick();
    cfg_we    = 1'b0;
    if (f < 10) mdl[l][f] = d;
  endtask

  task automatic wait_req(output int t);
    t = 0;
    while (req !== 1'b1 && t < 40) begin
      tick();
      t++;
    end
    if (req !== 1'b1) check("req_timeout", req, 1);
  endtask

  // One network pass. dly < 0 picks a random ack delay per layer. spur adds
  // ack-in-REQ plus start and cfg writes during WAIT. to_layer >= 0 withholds
  // ack on that layer (watchdog case).
  task automatic run(input int nl, input int dly, input bit spur, input int to_layer);
    int n, last, t, d;
    bit aborted, busy_ok;
    n       = (nl > LAYERS) ? LAYERS : nl;
    aborted = (to_layer >= 0 && to_layer < n);
    last    = aborted ? to_layer : n - 1;
    for (int i = 0; i <= last; i++) push_exp(0, i, exp_desc(i), 0);
    push_exp(1, 0, '0, aborted);

    start      = 1'b1;
    num_layers = NL_W'(nl);
    tick();
    start      = 1'b0;
    num_layers = '0;
    check("busy_cycle1", busy, 1);
    check("err_cleared", err, 0);

    for (int i = 0; i <= last; i++) begin
      wait_req(t);
      if (req !== 1'b1) return;
      check("req_latency", t, 1);
      if (spur) ack = 1'b1;           // ack coincident with req
      tick();
      ack = 1'b0;
      if (aborted && i == to_layer) begin
        t = 0;
        while (done !== 1'b1 && t < TO + 20) begin
          tick();
          t++;
        end
        check("wd_wait_cycles", t, TO);
        break;
      end
      d       = (dly >= 0) ? dly : int'($urandom_range(0, 6));
      busy_ok = 1'b1;
      for (int c = 0; c < d; c++) begin
        if (spur) begin
          start      = 1'b1;
          num_layers = NL_W'(1);
          cfg_we     = 1'b1;
          cfg_layer  = IDX_W'(i);
          cfg_field  = 4'($urandom_range(0, 9));
          cfg_wdata  = 16'($urandom);
        end
        busy_ok &= (busy === 1'b1);
        tick();
        start  = 1'b0;
        cfg_we = 1'b0;
      end
      check("busy_in_wait", busy_ok, 1);
      ack = 1'b1;
      tick();
      ack = 1'b0;
    end
    check("done_timing", done, 1);
    check("busy_at_done", busy, 1);
    tick();
    check("busy_after_done", busy, 0);
  endtask

  initial begin
    int t;
    rst        = 1'b1;
    cfg_we     = 1'b0;
    cfg_layer  = '0;
    cfg_field  = '0;
    cfg_wdata  = '0;
    start      = 1'b0;
    num_layers = '0;
    ack        = 1'b0;
    repeat (3) tick();
    check("reset_outputs", all_outs(), '0);
    rst = 1'b0;
    tick();

    // Three distinct layers, ack 20 cycles after each req.
    for (int l = 0; l < 3; l++) begin
      wr(l, 0, 16'(l * 16'h400));
      for (int f = 1; f < 10; f++) wr(l, f, 16'($urandom));
    end
    run(3, 20, 0, -1);

    // ack while idle must not start anything.
    ack = 1'b1;
    repeat (2) tick();
    ack = 1'b0;
    tick();
    check("idle_ack_busy", busy, 0);

    // Zero-layer pass.
    run(0, 0, 0, -1);

    // Spurious inputs, then rerun to show the table was not touched.
    run(2, 4, 1, -1);
    run(2, -1, 0, -1);

    // Fill the whole table with random data, including reserved fields.
    for (int l = 0; l < LAYERS; l++)
      for (int f = 0; f < 16; f++) wr(l, f, 16'($urandom));

    // Clamp: 20 requested, 16 issued.
    run(20, -1, 0, -1);

    // Random passes with random descriptor edits in between.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 4; k++)
        wr(int'($urandom_range(0, LAYERS-1)), int'($urandom_range(0, 15)), 16'($urandom));
      run(int'($urandom_range(0, LAYERS)), -1, 0, -1);
    end

    // Reset while waiting on layer 1.
    push_exp(0, 0, exp_desc(0), 0);
    push_exp(0, 1, exp_desc(1), 0);
    start      = 1'b1;
    num_layers = NL_W'(3);
    tick();
    start      = 1'b0;
    wait_req(t);
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    wait_req(t);
    repeat (2) tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
    check("reset_midrun_outputs", all_outs(), '0);
    rst = 1'b0;
    repeat (6) tick();
    run(2, -1, 0, -1);

`ifdef RENKON_SEQ_TIMEOUT_EN
    // Watchdog: withhold ack on layer 0 of a two-layer pass.
    run(2, -1, 0, 0);
    check("err_sticky", err, 1);
    // ack on the 8th wait cycle wins; the new start clears err.
    run(1, TO - 1, 0, -1);
    check("err_after_ok_run", err, 0);
`endif

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
